// File: rtl/uart_pkg.sv
// Shared types, constants and the round-robin pick helper for the UART
// transmit arbiter and related multi-source blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4
  } uart_arb_state_t;

  localparam int HANDSHAKE_TIMEOUT = 4;
  localparam int MAX_REQ           = 8;

  // First set bit of vec searching upward from ptr+1, wrapping modulo n.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] vec,
                                 input int ptr,
                                 input int n);
    int win;
    bit found;
    win   = 0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      int idx;
      idx = (ptr + k) % n;
      if (k <= n && !found && vec[3'(idx)]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bundle of requester byte streams plus the uart_tx control port seen by
// the arbiter.
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  // Requester i presents req_vld[i]/req_data/req_last and holds them stable
  // until req_ack[i] pulses; a byte moves on the cycle vld and ack are both
  // high. Towards uart_tx a byte moves on the cycle tx_dvld is high, which
  // happens only while tx_ready is high.
  logic [NUM_REQ-1:0]   req_vld;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 tx_dvld;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic                 tx_overflow;

  modport slave (
    input  req_vld, req_data, req_last, tx_ready, tx_overflow,
    output req_ack, tx_dvld, tx_data
  );

  modport master (
    output req_vld, req_data, req_last, tx_ready, tx_overflow,
    input  req_ack, tx_dvld, tx_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: lowest priority goes to pointer,
// highest to pointer+1.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     pointer_i,
  output logic               any_o,
  output logic [IDW-1:0]     idx_o
);

  assign any_o = |req_i;
  assign idx_o = IDW'(rr_pick(MAX_REQ'(req_i), int'(pointer_i), NUM_REQ));

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter sharing one uart_tx between NUM_REQ byte
// streams, pacing each byte on the transmitter's ready fall/rise.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_BURST    = 16,
  parameter  int LOCK_TIMEOUT = 1024,
  localparam int IDW          = $clog2(NUM_REQ),
  localparam int LKW          = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_arb_if.slave    bus,
  output logic            grant_vld,
  output logic [IDW-1:0]  grant_id,
  output logic            err_overflow,
  output logic            err_timeout,
  output logic            err_handshake,
  output uart_arb_state_t dbg_state_o
);

  uart_arb_state_t state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  grant_id_q;
  logic            grant_vld_q;
  logic [7:0]      cnt_q;
  logic [LKW-1:0]  lock_q;
  logic [2:0]      hs_q;
  logic            release_q;
  logic            tx_dvld_q;
  logic [7:0]      tx_data_q;
  logic            err_overflow_q;
  logic            err_timeout_q;
  logic            err_handshake_q;

  logic            arb_any;
  logic [IDW-1:0]  arb_idx;
  logic            g_vld;
  logic            g_last;
  logic [7:0]      g_data;
  logic            take;
  logic            burst_done;
  logic            lock_hit;
  logic            hs_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i     (bus.req_vld),
    .pointer_i (ptr_q),
    .any_o     (arb_any),
    .idx_o     (arb_idx)
  );

  assign g_vld      = bus.req_vld[grant_id_q];
  assign g_last     = bus.req_last[grant_id_q];
  assign g_data     = bus.req_data[{grant_id_q, 3'b000} +: 8];
  // Reset gates the ack so a packet interrupted by rst loses no byte.
  assign take       = !rst && (state_q == ST_SEND) && g_vld && bus.tx_ready;
  assign burst_done = ({1'b0, cnt_q} + 9'd1) == 9'(MAX_BURST);
  assign lock_hit   = (lock_q + 1'b1) == LKW'(LOCK_TIMEOUT);
  assign hs_hit     = (hs_q + 3'd1) == 3'(HANDSHAKE_TIMEOUT);

  always_comb begin
    bus.req_ack = '0;
    if (take) begin
      bus.req_ack[grant_id_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      ptr_q           <= IDW'(NUM_REQ - 1);
      grant_id_q      <= '0;
      grant_vld_q     <= 1'b0;
      cnt_q           <= '0;
      lock_q          <= '0;
      hs_q            <= '0;
      release_q       <= 1'b0;
      tx_dvld_q       <= 1'b0;
      tx_data_q       <= '0;
      err_overflow_q  <= 1'b0;
      err_timeout_q   <= 1'b0;
      err_handshake_q <= 1'b0;
    end else begin
      if (bus.tx_overflow) begin
        err_overflow_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_id_q  <= arb_idx;
            grant_vld_q <= 1'b1;
            ptr_q       <= arb_idx;
            cnt_q       <= '0;
            lock_q      <= '0;
            state_q     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (take) begin
            tx_data_q <= g_data;
            tx_dvld_q <= 1'b1;
            release_q <= g_last || burst_done;
            cnt_q     <= cnt_q + 8'd1;
            lock_q    <= '0;
            state_q   <= ST_ISSUE;
          end else if (!g_vld) begin
            // An owner that goes quiet mid-packet eventually loses the grant.
            if (lock_hit) begin
              err_timeout_q <= 1'b1;
              grant_vld_q   <= 1'b0;
              state_q       <= ST_IDLE;
            end else begin
              lock_q <= lock_q + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          tx_dvld_q <= 1'b0;
          hs_q      <= '0;
          state_q   <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!bus.tx_ready) begin
            state_q <= ST_WAIT_HI;
          end else if (hs_hit) begin
            err_handshake_q <= 1'b1;
            state_q         <= ST_WAIT_HI;
          end else begin
            hs_q <= hs_q + 3'd1;
          end
        end
        ST_WAIT_HI: begin
          if (bus.tx_ready) begin
            if (release_q) begin
              grant_vld_q <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              state_q <= ST_SEND;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_dvld   = tx_dvld_q;
  assign bus.tx_data   = tx_data_q;
  assign grant_vld     = grant_vld_q;
  assign grant_id      = grant_id_q;
  assign err_overflow  = err_overflow_q;
  assign err_timeout   = err_timeout_q;
  assign err_handshake = err_handshake_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a behavioural uart_tx ready model and
// an ordered scoreboard of {owner, byte} per issued tx_dvld.
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int MAX_BURST    = 16;
  localparam int LOCK_TIMEOUT = 1024;
  localparam int FRAME        = 6;
  localparam int W            = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

  logic            grant_vld;
  logic [1:0]      grant_id;
  logic            err_overflow;
  logic            err_timeout;
  logic            err_handshake;
  uart_arb_state_t dbg_state;

  uart_tx_arb #(
    .NUM_REQ      (NUM_REQ),
    .MAX_BURST    (MAX_BURST),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .grant_vld     (grant_vld),
    .grant_id      (grant_id),
    .err_overflow  (err_overflow),
    .err_timeout   (err_timeout),
    .err_handshake (err_handshake),
    .dbg_state_o   (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0]       exp_q[$];
  logic [W-1:0]       obs_q[$];
  logic [8:0]         pq[NUM_REQ][$];
  logic [NUM_REQ-1:0] en;
  logic [NUM_REQ-1:0] vld_s;
  logic [NUM_REQ-1:0] ack_s;
  logic               dvld_s;
  int                 txc;
  bit                 faulty;
  int                 cyc;
  int                 first_dvld;
  int                 first_ehs;
  int                 ack_cnt[NUM_REQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic drive();
    logic [NUM_REQ-1:0]   v;
    logic [NUM_REQ-1:0]   l;
    logic [8*NUM_REQ-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en[i] && pq[i].size() > 0) begin
        v[i]         = 1'b1;
        l[i]         = pq[i][0][8];
        d[8*i +: 8]  = pq[i][0][7:0];
      end
    end
    bus.req_vld  = v;
    bus.req_last = l;
    bus.req_data = d;
  endtask

  // One clock: sample at the falling edge, then update models after the rise.
  task automatic tick();
    @(negedge clk);
    ack_s  = bus.req_ack;
    vld_s  = bus.req_vld;
    dvld_s = bus.tx_dvld;
    if (dvld_s) begin
      obs_q.push_back({grant_id, bus.tx_data});
      if (first_dvld < 0) first_dvld = cyc;
      check("dvld_while_ready", 32'(bus.tx_ready), 32'd1);
    end
    if (ack_s != '0) begin
      check("ack_onehot", 32'($countones(ack_s)), 32'd1);
      check("ack_needs_vld", 32'(ack_s & ~vld_s), 32'd0);
    end
    if (err_handshake && first_ehs < 0) first_ehs = cyc;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack_s[i]) begin
        ack_cnt[i]++;
        if (pq[i].size() > 0) void'(pq[i].pop_front());
      end
    end
    if (faulty) begin
      txc = 0;
      bus.tx_ready = 1'b1;
    end else begin
      if (dvld_s) txc = FRAME + 1;
      else if (txc > 0) txc--;
      bus.tx_ready = (txc == 0) || (txc == FRAME + 1);
    end
    drive();
  endtask

  task automatic push_exp(input int id, input logic [7:0] b);
    exp_q.push_back({2'(id), b});
  endtask

  task automatic load(input int id, input int n, input int base_id);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      pq[id].push_back({(k == n - 1), b});
      push_exp(base_id, b);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(obs_q.size() >= exp_q.size() && !grant_vld && txc == 0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_budget"}, 32'(n < budget), 32'd1);
    repeat (10) tick();
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      check(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic clear_reqs();
    en = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pq[i].delete();
      ack_cnt[i] = 0;
    end
    drive();
  endtask

  initial begin
    logic [7:0] split[20];
    int n;
    bus.req_vld     = '0;
    bus.req_last    = '0;
    bus.req_data    = '0;
    bus.tx_ready    = 1'b1;
    bus.tx_overflow = 1'b0;
    en = '0;
    txc = 0;
    faulty = 1'b0;
    cyc = 0;
    first_dvld = -1;
    first_ehs = -1;
    for (int i = 0; i < NUM_REQ; i++) ack_cnt[i] = 0;

    // Reset values
    tick();
    tick();
    check("rst_grant_vld", 32'(grant_vld), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_tx_dvld", 32'(bus.tx_dvld), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_req_ack", 32'(bus.req_ack), 32'd0);
    check("rst_errs", 32'({err_overflow, err_timeout, err_handshake}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    // Single requester, three-byte packet
    pq[0].push_back({1'b0, 8'h55});
    pq[0].push_back({1'b0, 8'hA3});
    pq[0].push_back({1'b1, 8'h0F});
    push_exp(0, 8'h55);
    push_exp(0, 8'hA3);
    push_exp(0, 8'h0F);
    en = 4'b0001;
    drive();
    drain("single", 300);
    check("single_acks", 32'(ack_cnt[0]), 32'd3);
    check("single_grant_off", 32'(grant_vld), 32'd0);
    check("ovf_before", 32'(err_overflow), 32'd0);
    bus.tx_overflow = 1'b1;
    tick();
    bus.tx_overflow = 1'b0;
    tick();
    tick();
    check("ovf_sticky", 32'(err_overflow), 32'd1);

    // Three requesters valid from reset, one-byte packets each
    clear_reqs();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) load(i, 1, i);
    end
    en = 4'b0111;
    do_reset();
    check("rr_errs_cleared", 32'(err_overflow), 32'd0);
    drain("rr_order", 400);
    check("rr_errs", 32'({err_overflow, err_timeout, err_handshake}), 32'd0);

    // Burst split: 20-byte packet on 1 interleaved with 2-byte packet on 3
    clear_reqs();
    for (int k = 0; k < 20; k++) begin
      split[k] = 8'($urandom_range(0, 255));
      pq[1].push_back({(k == 19), split[k]});
    end
    for (int k = 0; k < MAX_BURST; k++) push_exp(1, split[k]);
    load(3, 2, 3);
    for (int k = MAX_BURST; k < 20; k++) push_exp(1, split[k]);
    en = 4'b1010;
    do_reset();
    drain("burst", 1500);
    check("burst_acks1", 32'(ack_cnt[1]), 32'd20);

    // Lock timeout: owner 2 goes quiet after one byte while 0 waits
    clear_reqs();
    do_reset();
    load(2, 3, 2);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    en = 4'b0100;
    drive();
    n = 0;
    while (ack_cnt[2] == 0 && n < 200) begin
      tick();
      n++;
    end
    check("lock_first_ack", 32'(ack_cnt[2]), 32'd1);
    en[2] = 1'b0;
    load(0, 1, 0);
    en[0] = 1'b1;
    drive();
    repeat (500) tick();
    check("lock_hold_err", 32'(err_timeout), 32'd0);
    check("lock_hold_vld", 32'(grant_vld), 32'd1);
    check("lock_hold_id", 32'(grant_id), 32'd2);
    drain("lock", 2000);
    check("lock_err", 32'(err_timeout), 32'd1);
    check("lock_no_hs", 32'(err_handshake), 32'd0);

    // Faulty transmitter: ready never falls
    clear_reqs();
    do_reset();
    faulty = 1'b1;
    first_dvld = -1;
    first_ehs = -1;
    load(0, 2, 0);
    en = 4'b0001;
    drive();
    drain("hs", 300);
    check("hs_err", 32'(err_handshake), 32'd1);
    check("hs_delay", 32'(first_ehs - first_dvld), 32'd5);
    check("hs_acks", 32'(ack_cnt[0]), 32'd2);
    faulty = 1'b0;

    // Reset during WAIT_LO; requester 0 must win first afterwards
    clear_reqs();
    do_reset();
    first_dvld = -1;
    load(0, 3, 0);
    load(1, 1, 1);
    en = 4'b0011;
    drive();
    n = 0;
    while (first_dvld < 0 && n < 100) begin
      tick();
      n++;
    end
    check("mid_state", 32'(dbg_state), 32'(ST_WAIT_LO));
    rst = 1'b1;
    tick();
    check("mid_grant_vld", 32'(grant_vld), 32'd0);
    check("mid_grant_id", 32'(grant_id), 32'd0);
    check("mid_tx_dvld", 32'(bus.tx_dvld), 32'd0);
    check("mid_tx_data", 32'(bus.tx_data), 32'd0);
    check("mid_req_ack", 32'(bus.req_ack), 32'd0);
    check("mid_errs", 32'({err_overflow, err_timeout, err_handshake}), 32'd0);
    rst = 1'b0;
    drain("post_rst", 500);
    check("post_rst_acks0", 32'(ack_cnt[0]), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
- Grants the transmitter per packet: one grant covers all bytes up to and including the byte flagged last, capped at MAX_BURST bytes.
- Paces each byte against the transmitter's dvld/ready handshake. The transmitter's ready stays high for one cycle after dvld, so the arbiter waits for ready to fall and then rise again before the next byte.
- Sits between firmware/packet sources and uart_tx; no other logic touches uart_tx's control port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, max bytes per grant before forced re-arbitration (1..255)
LOCK_TIMEOUT, 1024, cycles a granted requester may leave req_vld low mid-packet before the grant is revoked (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_vld  in  NUM_REQ  per-requester byte valid; data must stay stable until ack
req_data  in  8*NUM_REQ  byte for requester i at [8*i+7:8*i]
req_last  in  NUM_REQ  marks current byte as last of packet
req_ack  out  NUM_REQ  one-cycle pulse: byte consumed (combinational in SEND)
tx_dvld  out  1  to uart_tx dvld, registered
tx_data  out  8  to uart_tx data, registered
tx_ready  in  1  from uart_tx ready
tx_overflow  in  1  from uart_tx overflow
grant_vld  out  1  a requester currently owns the transmitter
grant_id  out  $clog2(NUM_REQ)  owner index, valid when grant_vld
err_overflow  out  1  sticky: tx_overflow seen
err_timeout  out  1  sticky: a grant was revoked by LOCK_TIMEOUT
err_handshake  out  1  sticky: tx_ready did not fall within 4 cycles after tx_dvld

Behaviour:
- Reset values:
  - req_ack=0, tx_dvld=0, tx_data=0, grant_vld=0, grant_id=0, all err_* = 0.
  - State IDLE; round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-packet drops the grant immediately with no ack. A tx_dvld already issued is not retracted; the transmitter's own reset governs it.
- States: IDLE, SEND, ISSUE, WAIT_LO, WAIT_HI.
- IDLE:
  - If any req_vld is high, pick the first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Register grant_id, set grant_vld=1, set pointer=winner, clear byte count, go SEND.
  - Grant is visible one cycle after req_vld is first seen.
- SEND:
  - If req_vld[g] && tx_ready: req_ack[g]=1 this cycle; capture tx_data=req_data[g]; set tx_dvld=1 for the next cycle only; set release=req_last[g] || (count+1==MAX_BURST); count++; go ISSUE.
  - If req_vld[g] is low, increment the lock counter (it is cleared on every ack). When it reaches LOCK_TIMEOUT: set err_timeout, grant_vld=0, go IDLE.
- ISSUE: tx_dvld high for exactly this cycle; go WAIT_LO.
- WAIT_LO:
  - Wait for tx_ready==0, then go WAIT_HI.
  - If 4 cycles pass without it: set err_handshake, go WAIT_HI.
- WAIT_HI:
  - Wait for tx_ready==1.
  - If release: grant_vld=0, go IDLE; the next grant comes one cycle later.
  - Otherwise go SEND.
- Minimum per-byte overhead: SEND→ISSUE→WAIT_LO(≥1)→WAIT_HI. Throughput is bounded by uart_tx, never by the arbiter.
- No request can starve: after the current owner's release, the owner has lowest priority.
- A requester may raise/lower req_vld freely when not granted. Non-granted requesters never see req_ack.
- Packet/burst interaction:
  - A packet longer than MAX_BURST is split: the grant is released and the requester competes again.
  - The byte after the split carries no special marking.
- Simultaneous last and MAX_BURST count as one release.
- At most one tx_dvld is outstanding; tx_dvld is never asserted while tx_ready is low.
- err_overflow is set on any cycle with tx_overflow=1. All err_* clear only on rst.

Decomposition:
- Package uart_pkg:
  - state enum uart_arb_state_t.
  - Constant HANDSHAKE_TIMEOUT=4.
  - Function rr_pick(vector, pointer), returning the winner index.
- Sub-module rr_arbiter (NUM_REQ param; inputs req, pointer; outputs any, idx): purely combinational, reused by later multi-source blocks.
- FSM, counters and registers live in uart_tx_arb.

Test Plan:
- Single requester 0 sends 3 bytes 0x55,0xA3,0x0F (last on 0x0F) → uart_tx line shows three frames in order; req_ack[0] pulses 3 times; grant_vld falls after the third WAIT_HI.
- Requesters 0,1,2 all valid from reset, 1-byte packets each → grant order 0,1,2,0,1,2; err_*=0.
- Requester 1 sends a 20-byte packet with MAX_BURST=16 while requester 3 waits → bytes 1–16 from requester 1, then requester 3's packet, then bytes 17–20.
- Granted requester 2 drops req_vld mid-packet for 1024 cycles (LOCK_TIMEOUT=1024) → err_timeout=1, grant_vld=0; requester 0's pending byte is sent next.
- tx_ready model held high after tx_dvld (faulty transmitter) → err_handshake=1 four cycles after ISSUE; the next byte is still issued.
- rst asserted during WAIT_LO of a multi-byte packet → next cycle all outputs at reset values; after release, requester 0 wins first.
